// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   ctrl_state_t    : sequencer state (RUN, MEM_WAIT)
//   MEM_TIMEOUT_DEF : default data-memory watchdog limit in cycles (>= 2)
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector. Purely combinational.
// Flags a load in EX whose non-zero destination feeds either source of the
// instruction in ID.
// Ports:
//   idExMemRead     in  instruction in EX is a load
//   idExRd          in  destination register of the EX instruction
//   ifIdRs1/Rs2     in  source registers of the ID instruction
//   loadUse         out hazard present this cycle
module load_use_detect (
  input  logic       idExMemRead,
  input  logic [4:0] idExRd,
  input  logic [4:0] ifIdRs1,
  input  logic [4:0] ifIdRs2,
  output logic       loadUse
);

  // x0 is hardwired to zero, so a load to it never creates a dependency.
  assign loadUse = idExMemRead && (idExRd != 5'd0) &&
                   ((idExRd == ifIdRs1) || (idExRd == ifIdRs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Resolves load-use bubbles, taken-branch squashes and multi-cycle data
// memory accesses (request/ready handshake with a timeout watchdog).
// All stall/flush/dmemReq/memFault outputs are combinational from state,
// wait counter and inputs.
// Optional feature: define PIPE_CTRL_PERF_EN to build the stallCycles and
// flushEvents performance counters; otherwise both read 0 and no counter
// flops exist.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   idExMemRead, idExRd            load in EX and its destination
//   ifIdRs1, ifIdRs2               sources of the instruction in ID
//   branchTaken                    branch/jump resolved taken in EX
//   exMemMemRead, exMemMemWrite    instruction in MEM accesses data memory
//   dmemReady                      data memory completes access this cycle
//   pcStall, *Stall                hold PC / pipeline registers
//   *Flush                         zero pipeline registers
//   dmemReq                        data-memory request
//   memFault                       one-cycle pulse on access timeout
//   stallCycles, flushEvents       performance counters
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; branch/load-use handled, new access may start
// MEM_WAIT | data access outstanding; pipeline frozen until ready/timeout
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idExMemRead,
  input  logic [4:0]  idExRd,
  input  logic [4:0]  ifIdRs1,
  input  logic [4:0]  ifIdRs2,
  input  logic        branchTaken,
  input  logic        exMemMemRead,
  input  logic        exMemMemWrite,
  input  logic        dmemReady,
  output logic        pcStall,
  output logic        ifIdStall,
  output logic        idExStall,
  output logic        exMemStall,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        exMemFlush,
  output logic        memWbFlush,
  output logic        dmemReq,
  output logic        memFault,
  output logic [31:0] stallCycles,
  output logic [31:0] flushEvents
);

  localparam int            CW       = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_TIMEOUT - 1);

  ctrl_state_t   state;
  logic [CW-1:0] waitCnt;
  logic          memAcc;
  logic          memStall;
  logic          loadUse;

  load_use_detect u_load_use_detect (
    .idExMemRead (idExMemRead),
    .idExRd      (idExRd),
    .ifIdRs1     (ifIdRs1),
    .ifIdRs2     (ifIdRs2),
    .loadUse     (loadUse)
  );

  assign memAcc = exMemMemRead | exMemMemWrite;

  always_comb begin
    pcStall    = 1'b0;
    ifIdStall  = 1'b0;
    idExStall  = 1'b0;
    exMemStall = 1'b0;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    exMemFlush = 1'b0;
    memWbFlush = 1'b0;
    dmemReq    = 1'b0;
    memFault   = 1'b0;
    memStall   = 1'b0;
    if (reset) begin
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
      exMemFlush = 1'b1;
      memWbFlush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          dmemReq  = memAcc;
          memStall = memAcc & ~dmemReady;
        end
        MEM_WAIT: begin
          dmemReq = 1'b1;
          if (!dmemReady) begin
            if (waitCnt == LAST_CNT) begin
              // Timeout: release the pipe but kill the faulting write-back.
              memFault   = 1'b1;
              memWbFlush = 1'b1;
            end else begin
              memStall = 1'b1;
            end
          end
        end
        default: ;
      endcase

      // Branch/load-use are evaluated on release cycles too, since the frozen
      // ID/EX still holds the instruction that raised them.
      if (memStall) begin
        pcStall    = 1'b1;
        ifIdStall  = 1'b1;
        idExStall  = 1'b1;
        exMemStall = 1'b1;
        memWbFlush = 1'b1;
      end else if (branchTaken) begin
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
      end else if (loadUse) begin
        pcStall   = 1'b1;
        ifIdStall = 1'b1;
        idExFlush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memAcc && !dmemReady) begin
            state   <= MEM_WAIT;
            waitCnt <= CW'(1);
          end
        end
        MEM_WAIT: begin
          if (dmemReady || (waitCnt == LAST_CNT)) begin
            state   <= RUN;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          waitCnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles <= '0;
      flushEvents <= '0;
    end else begin
      if (pcStall) stallCycles <= stallCycles + 32'd1;
      if (ifIdFlush || memFault) flushEvents <= flushEvents + 32'd1;
    end
  end
`else
  assign stallCycles = '0;
  assign flushEvents = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        idExMemRead = 1'b0;
  logic [4:0]  idExRd = '0;
  logic [4:0]  ifIdRs1 = '0;
  logic [4:0]  ifIdRs2 = '0;
  logic        branchTaken = 1'b0;
  logic        exMemMemRead = 1'b0;
  logic        exMemMemWrite = 1'b0;
  logic        dmemReady = 1'b0;
  logic        pcStall, ifIdStall, idExStall, exMemStall;
  logic        ifIdFlush, idExFlush, exMemFlush, memWbFlush;
  logic        dmemReq, memFault;
  logic [31:0] stallCycles, flushEvents;

  int checks = 0;
  int errors = 0;

  // Expected-output scoreboard: pushed when a cycle's stimulus is driven,
  // popped and compared mid-cycle once the combinational outputs settle.
  logic [9:0] exp_q[$];
  string      name_q[$];

  // {pcStall,ifIdStall,idExStall,exMemStall,ifIdFlush,idExFlush,exMemFlush,memWbFlush,dmemReq,memFault}
  localparam logic [9:0] E_RESET  = 10'b0000111100;
  localparam logic [9:0] E_IDLE   = 10'b0000000000;
  localparam logic [9:0] E_LU     = 10'b1100010000;
  localparam logic [9:0] E_BR     = 10'b0000110000;
  localparam logic [9:0] E_MSTALL = 10'b1111000110;
  localparam logic [9:0] E_REL    = 10'b0000000010;
  localparam logic [9:0] E_RELBR  = 10'b0000110010;
  localparam logic [9:0] E_FAULT  = 10'b0000000111;

  logic [9:0] obs;
  assign obs = {pcStall, ifIdStall, idExStall, exMemStall,
                ifIdFlush, idExFlush, exMemFlush, memWbFlush, dmemReq, memFault};

  pipeline_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .idExMemRead   (idExMemRead),
    .idExRd        (idExRd),
    .ifIdRs1       (ifIdRs1),
    .ifIdRs2       (ifIdRs2),
    .branchTaken   (branchTaken),
    .exMemMemRead  (exMemMemRead),
    .exMemMemWrite (exMemMemWrite),
    .dmemReady     (dmemReady),
    .pcStall       (pcStall),
    .ifIdStall     (ifIdStall),
    .idExStall     (idExStall),
    .exMemStall    (exMemStall),
    .ifIdFlush     (ifIdFlush),
    .idExFlush     (idExFlush),
    .exMemFlush    (exMemFlush),
    .memWbFlush    (memWbFlush),
    .dmemReq       (dmemReq),
    .memFault      (memFault),
    .stallCycles   (stallCycles),
    .flushEvents   (flushEvents)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", n, obs, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drives one cycle of inputs (called at posedge+1), records the expected
  // outputs, and returns just after the following rising edge.
  task automatic drive(input logic rst, input logic ldEx, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                       input logic mrd, input logic mwr, input logic rdy,
                       input logic [9:0] exp, input string name);
    reset = rst; idExMemRead = ldEx; idExRd = rd; ifIdRs1 = rs1; ifIdRs2 = rs2;
    branchTaken = br; exMemMemRead = mrd; exMemMemWrite = mwr; dmemReady = rdy;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string name);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE, name);
  endtask

  task automatic test_reset();
    drive(1, 1, 5, 5, 5, 1, 1, 0, 0, E_RESET, "reset_hold0");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, E_RESET, "reset_hold1");
    idle("after_reset");
    checks++;
    if (stallCycles !== 32'd0 || flushEvents !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stallCycles, flushEvents);
    end
  endtask

  task automatic test_perf_counters();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RESET, "perf_reset");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 9, 0, 9, 0, 0, 0, 0, E_LU, $sformatf("perf_lu%0d", i));
      idle($sformatf("perf_idle%0d", i));
    end
    checks++;
`ifdef PIPE_CTRL_PERF_EN
    if (stallCycles !== 32'd3 || flushEvents !== 32'd0) begin
      errors++;
      $display("FAIL perf_loaduse: got %0d/%0d expected 3/0", stallCycles, flushEvents);
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, E_BR, "perf_branch");
    checks++;
    if (flushEvents !== 32'd1 || stallCycles !== 32'd3) begin
      errors++;
      $display("FAIL perf_branch: got %0d/%0d expected 3/1", stallCycles, flushEvents);
    end
`else
    if (stallCycles !== 32'd0 || flushEvents !== 32'd0) begin
      errors++;
      $display("FAIL perf_tied: got %0d/%0d expected 0/0", stallCycles, flushEvents);
    end
`endif
  endtask

  task automatic test_load_use();
    drive(0, 1, 5, 0, 5, 0, 0, 0, 0, E_LU,   "lu_rs2");
    idle("lu_rs2_after");
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE, "lu_rd0");
    drive(0, 1, 7, 7, 3, 0, 0, 0, 0, E_LU,   "lu_rs1");
    drive(0, 0, 7, 7, 7, 0, 0, 0, 0, E_IDLE, "lu_not_load");
    drive(0, 1, 7, 6, 8, 0, 0, 0, 0, E_IDLE, "lu_no_match");
  endtask

  task automatic test_branch();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, E_BR, "br_alone");
    drive(0, 1, 5, 0, 5, 1, 0, 0, 0, E_BR, "br_over_lu");
    idle("br_after");
  endtask

  task automatic test_mem_ready();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, E_REL,    "mem_zero_wait");
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, E_MSTALL, "mem_w0");
    drive(0, 1, 4, 4, 0, 0, 1, 0, 0, E_MSTALL, "mem_w1_lu_masked");
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0, E_MSTALL, "mem_w2_br_masked");
    drive(0, 0, 0, 0, 0, 1, 1, 0, 1, E_RELBR,  "mem_release_br");
    idle("mem_after");
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 15; i++)
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, E_MSTALL, $sformatf("tmo_stall%0d", i));
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FAULT, "tmo_fault");
    idle("tmo_back_in_run");
  endtask

  task automatic test_reset_mid_wait();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, E_MSTALL, "rmw_start");
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, E_MSTALL, "rmw_wait1");
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, E_RESET,  "rmw_reset");
    checks++;
    if (stallCycles !== 32'd0 || flushEvents !== 32'd0) begin
      errors++;
      $display("FAIL rmw_counters: got %0d/%0d expected 0/0", stallCycles, flushEvents);
    end
    idle("rmw_run_no_fault");
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_perf_counters();
    test_load_use();
    test_branch();
    test_mem_ready();
    test_timeout();
    test_reset_mid_wait();
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
